// File: rtl/filter_blur_ctrl.sv
// Frame-aligned bypass control and video timing monitor for the blur filter.
// Tracks frame/line geometry, reports sticky errors and exposes the sync FSM state.
module filter_blur_ctrl #(
    parameter  int LINE_SIZE_MAX   = 1024,
    parameter  int FRAME_LINES_MAX = 1024,
    parameter  int TIMEOUT         = 1 << 24,
    localparam int PIX_W           = $clog2(LINE_SIZE_MAX + 1),
    localparam int LINE_W          = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              cfg_bypass_i,
    input  logic              cfg_wr_i,
    input  logic              err_clr_i,
    output logic              bypass_o,
    output logic              cfg_pend_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_cnt_o,
    output logic [PIX_W-1:0]  pix_cnt_o,
    output logic [LINE_W-1:0] line_cnt_o,
    output logic              err_ovf_o,
    output logic              err_geom_o,
    output logic              err_tmo_o,
    output logic [1:0]        state_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [PIX_W-1:0]  PIX_MAX  = PIX_W'(LINE_SIZE_MAX);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(FRAME_LINES_MAX);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        FRAME  = 2'd2
    } state_e;

    state_e             state_q;
    logic               vs_dly_q, de_dly_q;
    logic               shadow_q, pend_q, bypass_q, done_q;
    logic               ovf_q, geom_q, tmo_q, ref_vld_q;
    logic [15:0]        fcnt_q;
    logic [PIX_W-1:0]   pix_q, pix_out_q, ref_q;
    logic [LINE_W-1:0]  line_q, line_out_q;
    logic [TMO_W-1:0]   tmo_cnt_q;

    // Line sync carries no information the controller needs; de edges define lines.
    logic unused_hs;
    assign unused_hs = hs_i;

    logic vs_rise, vs_fall, line_end, in_frame, tmo_hit;
    logic set_ovf, set_geom, set_tmo;

    assign vs_rise  = vs_i & ~vs_dly_q;
    assign vs_fall  = ~vs_i & vs_dly_q;
    assign line_end = ~de_i & de_dly_q;
    assign in_frame = (state_q == FRAME);
    assign tmo_hit  = in_frame && (tmo_cnt_q == TMO_MAX);

    // A vs rise closes the frame, so a line end in that same cycle is dropped.
    assign set_ovf  = in_frame & ~vs_rise & ~tmo_hit & de_i & (pix_q == PIX_MAX);
    assign set_geom = in_frame & ~vs_rise & ~tmo_hit & line_end & ref_vld_q & (pix_q != ref_q);
    assign set_tmo  = ~vs_rise & tmo_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            vs_dly_q   <= 1'b0;
            de_dly_q   <= 1'b0;
            shadow_q   <= 1'b0;
            pend_q     <= 1'b0;
            bypass_q   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            geom_q     <= 1'b0;
            tmo_q      <= 1'b0;
            ref_vld_q  <= 1'b0;
            fcnt_q     <= '0;
            pix_q      <= '0;
            pix_out_q  <= '0;
            ref_q      <= '0;
            line_q     <= '0;
            line_out_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            vs_dly_q <= vs_i;
            de_dly_q <= de_i;
            done_q   <= 1'b0;

            // Set beats clear when both land in the same cycle.
            ovf_q  <= set_ovf  | (ovf_q  & ~err_clr_i);
            geom_q <= set_geom | (geom_q & ~err_clr_i);
            tmo_q  <= set_tmo  | (tmo_q  & ~err_clr_i);

            if (cfg_wr_i) begin
                shadow_q <= cfg_bypass_i;
                pend_q   <= 1'b1;
            end
            // Rise applies the pre-write shadow; a coinciding write stays pending.
            if (vs_rise) begin
                bypass_q <= shadow_q;
                if (!cfg_wr_i) pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    if (vs_rise) state_q <= VBLANK;
                end
                VBLANK: begin
                    tmo_cnt_q <= '0;
                    if (vs_fall) begin
                        state_q   <= FRAME;
                        pix_q     <= '0;
                        line_q    <= '0;
                        ref_vld_q <= 1'b0;
                    end
                end
                FRAME: begin
                    if (vs_rise) begin
                        state_q    <= VBLANK;
                        done_q     <= 1'b1;
                        fcnt_q     <= fcnt_q + 16'd1;
                        line_out_q <= line_q;
                        tmo_cnt_q  <= '0;
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        pix_q     <= '0;
                        line_q    <= '0;
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (line_end) begin
                            pix_out_q <= pix_q;
                            pix_q     <= '0;
                            if (line_q != LINE_MAX) line_q <= line_q + 1'b1;
                            if (!ref_vld_q) begin
                                ref_q     <= pix_q;
                                ref_vld_q <= 1'b1;
                            end
                        end else if (de_i && pix_q != PIX_MAX) begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bypass_o     = bypass_q;
    assign cfg_pend_o   = pend_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = fcnt_q;
    assign pix_cnt_o    = pix_out_q;
    assign line_cnt_o   = line_out_q;
    assign err_ovf_o    = ovf_q;
    assign err_geom_o   = geom_q;
    assign err_tmo_o    = tmo_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_filter_blur_ctrl.sv
// Directed plus randomized bench for filter_blur_ctrl; a frame/line-level
// reference model predicts every output after each stimulus phase.
module tb_filter_blur_ctrl;

    localparam int LSM = 16;
    localparam int FLM = 8;
    localparam int TMO = 100;
    localparam int PW  = $clog2(LSM + 1);
    localparam int LW  = $clog2(FLM + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic          cfg_bypass_i = 1'b0, cfg_wr_i = 1'b0, err_clr_i = 1'b0;
    logic          bypass_o, cfg_pend_o, frame_done_o;
    logic [15:0]   frame_cnt_o;
    logic [PW-1:0] pix_cnt_o;
    logic [LW-1:0] line_cnt_o;
    logic          err_ovf_o, err_geom_o, err_tmo_o;
    logic [1:0]    state_o;

    filter_blur_ctrl #(
        .LINE_SIZE_MAX(LSM), .FRAME_LINES_MAX(FLM), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .cfg_bypass_i(cfg_bypass_i), .cfg_wr_i(cfg_wr_i), .err_clr_i(err_clr_i),
        .bypass_o(bypass_o), .cfg_pend_o(cfg_pend_o), .frame_done_o(frame_done_o),
        .frame_cnt_o(frame_cnt_o), .pix_cnt_o(pix_cnt_o), .line_cnt_o(line_cnt_o),
        .err_ovf_o(err_ovf_o), .err_geom_o(err_geom_o), .err_tmo_o(err_tmo_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 vertical blanking, 2 active frame.
    int m_state, m_fcnt, m_pix, m_line, m_lines, m_ref;
    bit m_shadow, m_bypass, m_pend, m_done, m_ovf, m_geom, m_tmo, m_ref_vld;

    task automatic model_reset();
        m_state = 0; m_fcnt = 0; m_pix = 0; m_line = 0; m_lines = 0; m_ref = 0;
        m_shadow = 0; m_bypass = 0; m_pend = 0; m_done = 0;
        m_ovf = 0; m_geom = 0; m_tmo = 0; m_ref_vld = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},   32'(frame_done_o), 32'(m_done));
        chk({tag, ".fcnt"},   32'(frame_cnt_o),  32'(m_fcnt));
        chk({tag, ".pix"},    32'(pix_cnt_o),    32'(m_pix));
        chk({tag, ".line"},   32'(line_cnt_o),   32'(m_line));
        chk({tag, ".bypass"}, 32'(bypass_o),     32'(m_bypass));
        chk({tag, ".pend"},   32'(cfg_pend_o),   32'(m_pend));
        chk({tag, ".ovf"},    32'(err_ovf_o),    32'(m_ovf));
        chk({tag, ".geom"},   32'(err_geom_o),   32'(m_geom));
        chk({tag, ".tmo"},    32'(err_tmo_o),    32'(m_tmo));
        chk({tag, ".state"},  32'(state_o),      32'(m_state));
    endtask

    task automatic step(input logic de, input logic vs, input logic wr,
                        input logic wv, input logic clr);
        de_i = de; vs_i = vs; cfg_wr_i = wr; cfg_bypass_i = wv; err_clr_i = clr;
        @(posedge clk); #1;
        cfg_wr_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic rise(input string tag, input bit wr, input bit wv, input int hold);
        bit was_frame;
        was_frame = (m_state == 2);
        step(1'b0, 1'b1, wr, wv, 1'b0);
        m_bypass = m_shadow;
        if (wr) begin m_shadow = wv; m_pend = 1; end
        else m_pend = 0;
        m_done = was_frame;
        if (was_frame) begin
            m_fcnt = (m_fcnt + 1) % 65536;
            m_line = (m_lines > FLM) ? FLM : m_lines;
        end
        m_state = 1;
        check_all(tag);
        m_done = 0;
        for (int i = 0; i < hold; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fall();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_state = 2; m_lines = 0; m_ref_vld = 0;
        chk("fall.state", 32'(state_o), 32'(m_state));
    endtask

    task automatic line(input int len, input int gap, input int wr_at, input bit wv,
                        input int clr_at);
        int sat;
        for (int i = 0; i < len; i++) begin
            step(1'b1, 1'b0, 1'(i == wr_at), wv, 1'(i == clr_at));
            if (i == wr_at) begin m_shadow = wv; m_pend = 1; end
            if (i == clr_at) begin m_ovf = 0; m_geom = 0; m_tmo = 0; end
        end
        if (len > LSM) m_ovf = 1;
        sat = (len > LSM) ? LSM : len;
        for (int g = 0; g < gap; g++) begin
            hs_i = (g == 0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        hs_i = 1'b0;
        m_pix = sat;
        m_lines++;
        if (!m_ref_vld) begin m_ref = sat; m_ref_vld = 1; end
        else if (sat != m_ref) m_geom = 1;
        check_all("line");
    endtask

    task automatic clear_errs();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        m_ovf = 0; m_geom = 0; m_tmo = 0;
        check_all("clr");
    endtask

    initial begin
        int nl, base, len, wr_at;
        bit wv;
        model_reset();

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("idle");

        // Three 4x8 frames; the opening rise comes from IDLE
        rise("s1.first", 0, 0, 2);
        for (int f = 0; f < 3; f++) begin
            fall();
            for (int l = 0; l < 4; l++) line(8, 2, -1, 0, -1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            rise("s1.rise", 0, 0, 2);
        end
        chk("s1.fcnt", 32'(frame_cnt_o), 32'd3);
        chk("s1.line", 32'(line_cnt_o), 32'd4);

        // Mid-frame config write waits for the next frame boundary
        fall();
        line(8, 2, 3, 1, -1);
        chk("s2.pend", 32'(cfg_pend_o), 32'd1);
        chk("s2.byp_hold", 32'(bypass_o), 32'd0);
        line(8, 2, -1, 0, -1);
        rise("s2.rise", 0, 0, 2);
        chk("s2.byp_new", 32'(bypass_o), 32'd1);

        // Write coinciding with the rise: old shadow applied, new one pending
        fall();
        line(8, 2, 2, 0, -1);
        rise("s3.prep", 0, 0, 2);
        fall();
        line(8, 2, -1, 0, -1);
        rise("s3.coinc", 1, 1, 2);
        chk("s3.byp_old", 32'(bypass_o), 32'd0);
        fall();
        line(8, 2, -1, 0, -1);
        rise("s3.next", 0, 0, 2);
        chk("s3.byp_new", 32'(bypass_o), 32'd1);

        // Overflow with a clear on the last pixel (set wins), then geometry mismatch
        fall();
        line(20, 2, -1, 0, 19);
        chk("s4.ovf", 32'(err_ovf_o), 32'd1);
        chk("s4.pix", 32'(pix_cnt_o), 32'd16);
        rise("s4.r1", 0, 0, 2);
        fall();
        line(8, 2, -1, 0, -1);
        line(9, 2, -1, 0, -1);
        chk("s4.geom", 32'(err_geom_o), 32'd1);
        rise("s4.r2", 0, 0, 1);
        clear_errs();

        // Line counter saturation, then a partial line cut off by the rise
        fall();
        for (int l = 0; l < 10; l++) line(2, 1, -1, 0, -1);
        rise("sat.rise", 0, 0, 2);
        chk("sat.line", 32'(line_cnt_o), 32'(FLM));
        fall();
        line(6, 2, -1, 0, -1);
        line(6, 2, -1, 0, -1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rise("part.rise", 0, 0, 2);
        chk("part.pix", 32'(pix_cnt_o), 32'd6);

        // Timeout: vs stuck low in FRAME
        fall();
        repeat (150) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_state = 0; m_tmo = 1;
        check_all("s5.tmo");
        rise("s5.rise", 0, 0, 2);
        clear_errs();

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            nl   = $urandom_range(1, 4);
            base = $urandom_range(1, 20);
            fall();
            for (int l = 0; l < nl; l++) begin
                len   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : base;
                wr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
                wv    = 1'($urandom_range(0, 1));
                line(len, $urandom_range(1, 2), wr_at, wv, -1);
            end
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            wv = 1'($urandom_range(0, 1));
            rise("rnd.rise", ($urandom_range(0, 3) == 0), wv, $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) clear_errs();
        end

        // Reset asserted in the middle of a line
        fall();
        line(5, 2, -1, 0, -1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("s6.inrst");
        de_i = 1'b0; vs_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("s6.post");
        rise("s6.first", 0, 0, 2);
        chk("s6.nodone", 32'(frame_cnt_o), 32'd0);
        fall();
        line(8, 2, -1, 0, -1);
        rise("s6.full", 0, 0, 2);
        chk("s6.fcnt", 32'(frame_cnt_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/filter_blur_ctrl.md
FILTER_BLUR_CTRL -- requirements
Module: filter_blur_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE_MAX, default 1024: maximum active pixels per line.
REQ-002 SHALL have parameter FRAME_LINES_MAX, default 1024: maximum active lines per frame.
REQ-003 SHALL have parameter TIMEOUT, default 2^24: clock cycles allowed in FRAME without a frame end.
REQ-004 clk  input  1  the single clock; all logic on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 de_i / hs_i / vs_i  input  1 each  video timing; vs_i high = vertical blanking.
REQ-007 cfg_bypass_i  input  1  requested filter bypass value.
REQ-008 cfg_wr_i  input  1  single-cycle strobe that loads cfg_bypass_i into the shadow register.
REQ-009 err_clr_i  input  1  single-cycle strobe that clears the sticky error flags.
REQ-010 bypass_o  output  1  bypass value driven to the blur filter, frame-aligned.
REQ-011 cfg_pend_o  output  1  shadow value written and not yet applied.
REQ-012 frame_done_o  output  1  one-cycle pulse at each completed frame.
REQ-013 frame_cnt_o  output  16  number of completed frames, wrapping.
REQ-014 pix_cnt_o  output  clog2(LINE_SIZE_MAX+1)  length of the last completed line.
REQ-015 line_cnt_o  output  clog2(FRAME_LINES_MAX+1)  active-line count of the last completed frame.
REQ-016 err_ovf_o / err_geom_o / err_tmo_o  output  1 each  sticky flags: line overflow, unequal line lengths, timeout.
REQ-017 state_o  output  2  FSM state: 0 IDLE, 1 VBLANK, 2 FRAME.

Function
REQ-018 All outputs SHALL be registered; vs_i and de_i SHALL be registered once each (vs_d, de_d) for edge detection.
REQ-019 Frame end (vs rise) SHALL be the cycle with vs_i=1 and vs_d=0; frame start (vs fall) SHALL be the cycle with vs_i=0 and vs_d=1; line end SHALL be the cycle with de_i=0 and de_d=1.
REQ-020 FSM transitions SHALL be as follows:
- IDLE to VBLANK on vs rise.
- VBLANK to FRAME on vs fall.
- FRAME to VBLANK on vs rise.
- FRAME to IDLE when the timeout counter reaches TIMEOUT.
REQ-021 Every vs rise SHALL load bypass_o from the shadow register and clear cfg_pend_o, with outputs updating at the edge where the rise is detected.
- This applies in every state.
REQ-022 If cfg_wr_i coincides with a vs rise, bypass_o SHALL take the old shadow value, the shadow SHALL take the new value, and cfg_pend_o SHALL remain 1.
REQ-023 On a vs rise in FRAME:
- frame_done_o SHALL pulse for one cycle.
- frame_cnt_o SHALL increment, wrapping 0xFFFF to 0.
- line_cnt_o SHALL take the frame line counter.
REQ-024 A vs rise in IDLE SHALL NOT pulse frame_done_o or change frame_cnt_o.
REQ-025 Pixel and line counting in FRAME:
- The pixel counter SHALL increment on each de_i=1 cycle and saturate at LINE_SIZE_MAX.
- On a line end, pix_cnt_o SHALL take the counter, the counter SHALL reset, and the line counter SHALL increment, saturating at FRAME_LINES_MAX.
REQ-026 de_i=1 while the pixel counter equals LINE_SIZE_MAX SHALL set err_ovf_o.
REQ-027 The first line end of a frame SHALL store a reference length; any later line end with a different length in that frame SHALL set err_geom_o.
REQ-028 Counter clearing:
- The timeout counter SHALL count cycles in FRAME and clear on vs fall, on vs rise, and outside FRAME.
- Reaching TIMEOUT SHALL set err_tmo_o and clear the pixel and line counters.
REQ-029 err_clr_i SHALL clear all three error flags; a set condition in the same cycle SHALL take priority over the clear.
REQ-030 A frame end SHALL NOT change pix_cnt_o.
REQ-031 A partial line cut off by a vs rise SHALL NOT be counted.
REQ-032 Entering FRAME SHALL clear the pixel and line counters and the reference-valid flag.

Reset
REQ-033 Asserting rst (low) SHALL immediately reset state, all counters, all flags, the shadow register, vs_d and de_d.
- All outputs SHALL be 0.
- bypass_o SHALL be 0, i.e. the filter is active.
REQ-034 Reset asserted mid-frame SHALL discard the frame; after release, operation SHALL resume from IDLE with no frame_done_o until a full VBLANK/FRAME/vs-rise sequence completes.

Verification
REQ-035 Scenario 1: 3 frames of 4 lines × 8 pixels, blanking between lines.
- Required: frame_done_o pulses 3 times, frame_cnt_o=3 (the first vs rise comes from IDLE), line_cnt_o=4, pix_cnt_o=8, no error flags.
REQ-036 Scenario 2: cfg_wr_i with cfg_bypass_i=1 mid-frame.
- Required: cfg_pend_o=1, and bypass_o stays 0 until the next vs rise, then bypass_o=1 and cfg_pend_o=0.
REQ-037 Scenario 3: cfg_wr_i in the same cycle as a vs rise, shadow previously 0, cfg_bypass_i=1.
- Required: bypass_o stays 0 and cfg_pend_o=1; the next vs rise gives bypass_o=1.
REQ-038 Scenario 4: LINE_SIZE_MAX=16, a line of 20 pixels.
- Required: err_ovf_o=1 and pix_cnt_o=16.
- Then lines of 8 and 9 pixels in one frame: err_geom_o=1.
- Then err_clr_i: both flags clear.
REQ-039 Scenario 5: TIMEOUT=100, vs_i held low for 150 cycles in FRAME.
- Required: err_tmo_o=1 and state_o=0.
- The next vs rise gives state_o=1 and no frame_done_o.
REQ-040 Scenario 6: rst pulsed low mid-frame.
- Required: all outputs 0 within the reset cycle.
- The first subsequent vs rise gives no frame_done_o.
